// File: rtl/nios_mul_sequencer.sv
// nios_mul_sequencer
// Drives a 3-product 16x16 multiplier cell through one pass (low word) or
// two passes (high word) to build a 32x32 multiply. Requests and results
// use valid/ready handshakes.
// Optional feature: define NIOS_MUL_SIGNED_EN to add req_signed and return
// the signed high word.
module nios_mul_sequencer #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_hi,
`ifdef NIOS_MUL_SIGNED_EN
  input  logic        req_signed,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] mc_src1,
  output logic [31:0] mc_src2,
  output logic        mc_en,
  input  logic [31:0] mc_p1,
  input  logic [31:0] mc_p2,
  input  logic [31:0] mc_p3
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT2,
    RESP
  } state_t;

  localparam logic [2:0] LAT = 3'(CELL_LAT);

  state_t      state;
  state_t      state_nxt;
  logic        hi_q;
  logic [2:0]  cnt;
  logic [32:0] mid_acc;
  logic [31:0] p1_q;
  logic [31:0] rsp_q;

  logic        cnt_last;
  logic [32:0] mid_now;
  logic [31:0] lo_word;
  logic [16:0] carry_hi;
  logic [31:0] hi_word;

`ifdef NIOS_MUL_SIGNED_EN
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        sgn_q;
`endif

  // The wait states end on the CELL_LAT-th cycle after the issue cycle.
  assign cnt_last = (cnt == 3'd1);

  // Cross-term sum and low word straight from the cell after pass 1.
  // The high word adds the carry out of (mid<<16)+p1 to a_hi*b_hi, which the
  // cell presents on mc_p1 after pass 2.
  always_comb begin
    mid_now  = {1'b0, mc_p2} + {1'b0, mc_p3};
    lo_word  = mc_p1 + {mid_now[15:0], 16'h0000};
    carry_hi = 17'(({mid_acc, 16'h0000} + {17'h0, p1_q}) >> 32);
    hi_word  = mc_p1 + {15'h0, carry_hi};
`ifdef NIOS_MUL_SIGNED_EN
    if (sgn_q) begin
      hi_word = hi_word - (a_q[31] ? b_q : 32'h0) - (b_q[31] ? a_q : 32'h0);
    end
`endif
  end

  // Next-state and handshake/enable decode.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mc_en     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ISSUE1;
      end
      ISSUE1: begin
        mc_en     = 1'b1;
        state_nxt = WAIT1;
      end
      WAIT1: begin
        if (cnt_last) state_nxt = hi_q ? ISSUE2 : RESP;
      end
      ISSUE2: begin
        mc_en     = 1'b1;
        state_nxt = WAIT2;
      end
      WAIT2: begin
        if (cnt_last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, operand capture, latency counter and result registers.
  // The pass-2 operands come from mc_src1/2 themselves, which still hold the
  // full operands from pass 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      hi_q    <= 1'b0;
      cnt     <= 3'd0;
      mid_acc <= 33'd0;
      p1_q    <= 32'd0;
      rsp_q   <= 32'd0;
      mc_src1 <= 32'd0;
      mc_src2 <= 32'd0;
`ifdef NIOS_MUL_SIGNED_EN
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            hi_q    <= req_hi;
            mc_src1 <= req_a;
            mc_src2 <= req_b;
`ifdef NIOS_MUL_SIGNED_EN
            a_q     <= req_a;
            b_q     <= req_b;
            sgn_q   <= req_signed & req_hi;
`endif
          end
        end
        ISSUE1, ISSUE2: begin
          cnt <= LAT;
        end
        WAIT1: begin
          cnt <= cnt - 3'd1;
          if (cnt_last) begin
            mid_acc <= mid_now;
            p1_q    <= mc_p1;
            if (hi_q) begin
              mc_src1 <= {16'h0000, mc_src1[31:16]};
              mc_src2 <= {16'h0000, mc_src2[31:16]};
            end else begin
              rsp_q <= lo_word;
            end
          end
        end
        WAIT2: begin
          cnt <= cnt - 3'd1;
          if (cnt_last) rsp_q <= hi_word;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data = rsp_q;

endmodule
